// File: rtl/if_prefetch_unit_if.sv
// Bus bundle between the instruction prefetch unit, the instruction RAM and decode.
// The perf-counter signals exist only when IFU_PERF_CNT_EN is defined.
interface if_prefetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  i_redirect_valid;
    logic [ADDR_WIDTH-1:0] i_redirect_pc;
    logic                  o_imem_req;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [DATA_WIDTH-1:0] i_imem_rdata;
    logic                  o_inst_valid;
    logic [DATA_WIDTH-1:0] o_inst;
    logic [ADDR_WIDTH-1:0] o_inst_pc;
    logic                  i_inst_ready;
    logic [CNT_W-1:0]      o_fifo_count;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]           o_perf_delivered;
    logic [31:0]           o_perf_flushed;
`endif

    modport master (
        input  i_redirect_valid, i_redirect_pc, i_imem_rdata, i_inst_ready,
`ifdef IFU_PERF_CNT_EN
        output o_perf_delivered, o_perf_flushed,
`endif
        output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_fifo_count
    );

    modport slave (
        output i_redirect_valid, i_redirect_pc, i_imem_rdata, i_inst_ready,
`ifdef IFU_PERF_CNT_EN
        input  o_perf_delivered, o_perf_flushed,
`endif
        input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_fifo_count
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch front end: credit-limited sequential fetch into a FIFO_DEPTH queue.
// Define IFU_PERF_CNT_EN to add delivered/flushed performance counters.
module if_prefetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    if_prefetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CNT_W:0]        DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] inst_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  head_valid;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // Credit counts the in-flight word so the queue can never overflow.
    // A redirect discards the response arriving in its own cycle, which is the
    // only one that can be outstanding, so no separate kill flag is needed.
    always_comb begin
        head_valid = (count != '0);
        issue      = !rst && !bus.i_redirect_valid &&
                     (((CNT_W + 1)'(count) + (CNT_W + 1)'(inflight)) < DEPTH_W);
        push       = inflight && !bus.i_redirect_valid;
        pop        = head_valid && bus.i_inst_ready && !bus.i_redirect_valid;
    end

    assign bus.o_imem_req   = issue;
    assign bus.o_imem_addr  = fetch_pc;
    assign bus.o_inst_valid = head_valid;
    assign bus.o_inst       = inst_mem[rd_ptr];
    assign bus.o_inst_pc    = pc_mem[rd_ptr];
    assign bus.o_fifo_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.i_redirect_valid) begin
            fetch_pc <= bus.i_redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                resp_pc  <= fetch_pc;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_mem[wr_ptr] <= bus.i_imem_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_delivered;
    logic [31:0] perf_flushed;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_delivered <= '0;
            perf_flushed   <= '0;
        end else begin
            if (pop)
                perf_delivered <= perf_delivered + 32'd1;
            if (bus.i_redirect_valid)
                perf_flushed <= perf_flushed + 32'(count) + 32'(inflight);
        end
    end

    assign bus.o_perf_delivered = perf_delivered;
    assign bus.o_perf_flushed   = perf_flushed;
`endif
endmodule
